rob_alloc_ctrl: RTL and testbench

Allocation and retirement controller for the reorder buffer. It owns the ROB head/tail pointers, occupancy count and per-entry completion bits. It hands Dispatch the ROB index for each new entry, marks entries complete on writeback and presents the oldest completed entry to commit. It sits between Dispatch, the ROB entry storage and the writeback/commit paths, and supplies the ROB index that the Dispatch–ROB interface carries alongside each new entry.

---
 rtl/rob_alloc_ctrl_pkg.sv | 17 +
 rtl/rob_alloc_ctrl_live_chk.sv | 20 ++
 rtl/rob_alloc_ctrl.sv | 146 ++++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared types and constants for the ROB allocation/retirement controller.
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH_C = 32;
  localparam int ROB_IDX_W_C = $clog2(ROB_DEPTH_C);

  // Entry index and wrap-extended pointer for the default depth.
  typedef logic [ROB_IDX_W_C-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W_C:0]   rob_ptr_t;

  // RUN: normal operation; RECOVER: one quiet cycle after a squash.
  typedef enum logic {
    ROB_RUN     = 1'b0,
    ROB_RECOVER = 1'b1
  } rob_ctrl_state_e;

endpackage

// File: rtl/rob_alloc_ctrl_live_chk.sv
// Combinational "index lies in [head, tail)" test on wrap-extended pointers.
// The index is live when its distance from head is below the occupancy.
module rob_ptr_live_chk #(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W:0]   i_head_ptr,
  input  logic [IDX_W:0]   i_tail_ptr,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_live
);

  logic [IDX_W:0]   w_count;
  logic [IDX_W-1:0] w_offset;

  assign w_count  = i_tail_ptr - i_head_ptr;
  // Modulo-depth distance from the oldest entry.
  assign w_offset = i_idx - i_head_ptr[IDX_W-1:0];
  assign o_live   = ({1'b0, w_offset} < w_count);

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation and retirement controller: owns head/tail pointers, the
// per-entry completion bits and the RUN/RECOVER state.
//
// Handshakes: an allocation happens on a cycle where disp_valid && disp_ready,
// a retirement on a cycle where commit_valid && commit_ready. Both *_valid /
// *_ready outputs depend only on registered state plus flush_valid, never on
// the partner's valid/ready input, so no combinational loop can form.
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_C,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  output logic [IDX_W-1:0] disp_rob_idx,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rob_idx,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [IDX_W-1:0] commit_rob_idx,
  input  logic             flush_valid,
  input  logic             flush_all,
  input  logic [IDX_W-1:0] flush_rob_idx,
  output logic [IDX_W:0]   rob_count,
  output logic             rob_empty,
  output logic             rob_full,
  output rob_ctrl_state_e  dbg_state
);

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]     r_head;
  logic [IDX_W:0]     r_tail;
  logic [ROB_DEPTH-1:0] r_done;
  rob_ctrl_state_e    r_state;
  rob_ctrl_state_e    w_state_nxt;

  logic [IDX_W:0]   w_head_nxt;
  logic [IDX_W:0]   w_tail_nxt;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W-1:0] w_flush_off;
  logic             w_empty;
  logic             w_full;
  logic             w_run;
  logic             w_alloc;
  logic             w_commit;
  logic             w_wb_live;
  logic             w_flush_live;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_run      = (r_state == ROB_RUN);

  assign disp_ready     = w_run && !w_full && !flush_valid;
  assign disp_rob_idx   = w_tail_idx;
  assign commit_valid   = w_run && !w_empty && r_done[w_head_idx] && !flush_valid;
  assign commit_rob_idx = w_head_idx;
  assign rob_count      = r_tail - r_head;
  assign rob_empty      = w_empty;
  assign rob_full       = w_full;
  assign dbg_state      = r_state;

  assign w_alloc     = disp_valid && disp_ready;
  assign w_commit    = commit_valid && commit_ready;
  assign w_flush_off = flush_rob_idx - w_head_idx;

  // Writeback is only honoured for entries that are currently allocated.
  rob_ptr_live_chk #(.IDX_W(IDX_W)) u_wb_live (
    .i_head_ptr (r_head),
    .i_tail_ptr (r_tail),
    .i_idx      (wb_rob_idx),
    .o_live     (w_wb_live)
  );

  // A partial flush must name a surviving entry to move the tail.
  rob_ptr_live_chk #(.IDX_W(IDX_W)) u_flush_live (
    .i_head_ptr (r_head),
    .i_tail_ptr (r_tail),
    .i_idx      (flush_rob_idx),
    .o_live     (w_flush_live)
  );

  // Next pointer values; a flush overrides dispatch and commit.
  always_comb begin
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    if (flush_valid) begin
      if (flush_all) begin
        w_tail_nxt = r_head;
      end else if (w_flush_live) begin
        w_tail_nxt = r_head + {1'b0, w_flush_off} + PTR_ONE;
      end
    end else begin
      if (w_alloc)  w_tail_nxt = r_tail + PTR_ONE;
      if (w_commit) w_head_nxt = r_head + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  // Completion bits: cleared on allocation, set by writeback to a live entry.
  // The allocated slot is never live, so the two updates cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= '0;
    end else begin
      if (w_alloc) r_done[w_tail_idx] <= 1'b0;
      if (wb_valid && w_wb_live) r_done[wb_rob_idx] <= 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ROB_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: any flush parks the controller in RECOVER for a cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ROB_RUN:     if (flush_valid)  w_state_nxt = ROB_RECOVER;
      ROB_RECOVER: if (!flush_valid) w_state_nxt = ROB_RUN;
      default:     w_state_nxt = ROB_RUN;
    endcase
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed scenarios plus randomized traffic,
// all compared against a sequence-number model of the reorder buffer.
module tb_rob_alloc_ctrl;
  import rob_alloc_ctrl_pkg::*;

  localparam int DEPTH = 32;
  localparam int IW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          disp_valid = 0, wb_valid = 0, commit_ready = 0;
  logic          flush_valid = 0, flush_all = 0;
  logic [IW-1:0] wb_rob_idx = '0, flush_rob_idx = '0;
  logic          disp_ready, commit_valid, rob_empty, rob_full;
  logic [IW-1:0] disp_rob_idx, commit_rob_idx;
  logic [IW:0]   rob_count;
  rob_ctrl_state_e dbg_state;

  rob_alloc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rob_idx(commit_rob_idx),
    .flush_valid(flush_valid), .flush_all(flush_all), .flush_rob_idx(flush_rob_idx),
    .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Entries are numbered by an ever-increasing sequence number; the live set
  // is [m_head, m_tail) and an entry's ROB index is its sequence number mod DEPTH.
  int m_head, m_tail;
  bit m_done[DEPTH];
  bit m_recover;
  bit e_ready, e_cvalid, e_empty, e_full;
  int e_didx, e_cidx, e_count;

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    foreach (m_done[i]) m_done[i] = 1'b0;
    m_recover = 1'b0;
  endtask

  function automatic bit is_live(int idx);
    for (int k = 0; k < m_tail - m_head; k++)
      if ((m_head + k) % DEPTH == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_expect();
    e_count  = m_tail - m_head;
    e_empty  = (e_count == 0);
    e_full   = (e_count == DEPTH);
    e_didx   = m_tail % DEPTH;
    e_cidx   = m_head % DEPTH;
    e_ready  = !m_recover && !e_full && !flush_valid;
    e_cvalid = !m_recover && !e_empty && m_done[m_head % DEPTH] && !flush_valid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit dv, input bit wv, input int wi, input bit cr,
                       input bit fv, input bit fa, input int fi);
    disp_valid    = dv;
    wb_valid      = wv;
    wb_rob_idx    = wi[IW-1:0];
    commit_ready  = cr;
    flush_valid   = fv;
    flush_all     = fa;
    flush_rob_idx = fi[IW-1:0];
    #1;
    model_expect();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model with the inputs of this cycle, then step the clock.
  task automatic tick();
    bit alloc, commit, wb_live, fl_live;
    alloc   = disp_valid && e_ready;
    commit  = commit_ready && e_cvalid;
    wb_live = wb_valid && is_live(int'(wb_rob_idx));
    fl_live = is_live(int'(flush_rob_idx));
    if (flush_valid) begin
      if (flush_all) begin
        m_tail = m_head;
      end else if (fl_live) begin
        for (int k = 0; k < m_tail - m_head; k++)
          if ((m_head + k) % DEPTH == int'(flush_rob_idx)) begin
            m_tail = m_head + k + 1;
            break;
          end
      end
      m_recover = 1'b1;
    end else begin
      if (alloc) begin
        m_done[m_tail % DEPTH] = 1'b0;
        m_tail++;
      end
      if (commit) m_head++;
      m_recover = 1'b0;
    end
    if (wb_live) m_done[int'(wb_rob_idx)] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    n_vec++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready got %0b expected 1", disp_ready); end
    n_vec++; if (disp_rob_idx !== 5'd0) begin n_err++; $display("FAIL reset_disp_idx got %0d expected 0", disp_rob_idx); end
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got %0b expected 0", commit_valid); end
    n_vec++; if (commit_rob_idx !== 5'd0) begin n_err++; $display("FAIL reset_commit_idx got %0d expected 0", commit_rob_idx); end
    n_vec++; if (rob_count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d expected 0", rob_count); end
    n_vec++; if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%0b full=%0b expected empty=1 full=0", rob_empty, rob_full); end
    n_vec++; if (dbg_state !== ROB_RUN) begin n_err++; $display("FAIL reset_state got %0d expected %0d", dbg_state, ROB_RUN); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (disp_ready !== 1'b1 || int'(disp_rob_idx) != i) begin
        n_err++; $display("FAIL fill_alloc got ready=%0b idx=%0d expected ready=1 idx=%0d", disp_ready, disp_rob_idx, i);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (rob_full !== 1'b1 || rob_count !== 6'd32) begin n_err++; $display("FAIL fill_full got full=%0b count=%0d expected full=1 count=32", rob_full, rob_count); end
    n_vec++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL fill_33rd_ready got %0b expected 0", disp_ready); end
    tick();
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    idle(); tick();
  endtask

  task automatic test_wb_order();
    repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0); tick(); end
    drive(0, 1, 2, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL wb_not_yet got %0b expected 0", commit_valid); end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    n_vec++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'd0) begin n_err++; $display("FAIL wb_commit0 got v=%0b idx=%0d expected v=1 idx=0", commit_valid, commit_rob_idx); end
    tick();
    drive(0, 1, 1, 1, 0, 0, 0);
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL wb_hold_idx1 got %0b expected 0", commit_valid); end
    tick();
    for (int i = 1; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      n_vec++; if (commit_valid !== 1'b1 || int'(commit_rob_idx) != i) begin
        n_err++; $display("FAIL wb_b2b_commit got v=%0b idx=%0d expected v=1 idx=%0d", commit_valid, commit_rob_idx, i);
      end
      tick();
    end
    idle();
    n_vec++; if (rob_empty !== 1'b1 || rob_count !== 6'd0) begin n_err++; $display("FAIL wb_empty got empty=%0b count=%0d expected empty=1 count=0", rob_empty, rob_count); end
    tick();
  endtask

  task automatic test_full_commit();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, (i == 1), 0, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 1, 0, 0, 0);
    n_vec++; if (disp_ready !== 1'b0 || commit_valid !== 1'b1 || rob_full !== 1'b1) begin
      n_err++; $display("FAIL full_commit_cycle got ready=%0b cvalid=%0b full=%0b expected 0 1 1", disp_ready, commit_valid, rob_full);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (disp_ready !== 1'b1 || disp_rob_idx !== 5'd0) begin n_err++; $display("FAIL full_reopen got ready=%0b idx=%0d expected ready=1 idx=0", disp_ready, disp_rob_idx); end
    tick();
    idle();
    n_vec++; if (rob_count !== 6'd32 || rob_full !== 1'b1 || commit_rob_idx !== 5'd1) begin
      n_err++; $display("FAIL full_wrapped got count=%0d full=%0b head=%0d expected 32 1 1", rob_count, rob_full, commit_rob_idx);
    end
    tick();
  endtask

  task automatic test_partial_flush();
    int guard;
    pulse_reset();
    for (int i = 0; i < 30; i++) begin drive(1, (i > 0), i - 1, 0, 0, 0, 0); tick(); end
    drive(0, 1, 29, 0, 0, 0, 0); tick();
    guard = 0;
    while (m_head < 30 && guard < 40) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      n_vec++; if (commit_valid !== e_cvalid) begin n_err++; $display("FAIL pf_drain_cvalid got %0b expected %0b", commit_valid, e_cvalid); end
      tick();
      guard++;
    end
    n_vec++; if (m_head != 30) begin n_err++; $display("FAIL pf_drain_timeout got head=%0d expected 30", m_head); end
    repeat (7) begin drive(1, 0, 0, 0, 0, 0, 0); tick(); end
    idle();
    n_vec++; if (rob_count !== 6'd7 || commit_rob_idx !== 5'd30 || disp_rob_idx !== 5'd5) begin
      n_err++; $display("FAIL pf_setup got count=%0d head=%0d tail=%0d expected 7 30 5", rob_count, commit_rob_idx, disp_rob_idx);
    end
    tick();
    drive(1, 0, 0, 0, 1, 0, 1);
    n_vec++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL pf_flush_ready got %0b expected 0", disp_ready); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (rob_count !== 6'd4 || disp_ready !== 1'b0 || dbg_state !== ROB_RECOVER) begin
      n_err++; $display("FAIL pf_recover got count=%0d ready=%0b state=%0d expected 4 0 1", rob_count, disp_ready, dbg_state);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    n_vec++; if (disp_ready !== 1'b1 || disp_rob_idx !== 5'd2) begin n_err++; $display("FAIL pf_resume got ready=%0b idx=%0d expected ready=1 idx=2", disp_ready, disp_rob_idx); end
    tick();
  endtask

  task automatic test_flush_all();
    drive(0, 1, 30, 0, 0, 0, 0); tick();
    drive(1, 1, 31, 1, 1, 1, 0);
    n_vec++; if (disp_ready !== 1'b0 || commit_valid !== 1'b0) begin n_err++; $display("FAIL fa_same_cycle got ready=%0b cvalid=%0b expected 0 0", disp_ready, commit_valid); end
    tick();
    idle();
    n_vec++; if (rob_count !== 6'd0 || rob_empty !== 1'b1 || dbg_state !== ROB_RECOVER) begin
      n_err++; $display("FAIL fa_after got count=%0d empty=%0b state=%0d expected 0 1 1", rob_count, rob_empty, dbg_state);
    end
    n_vec++; if (commit_rob_idx !== 5'd30) begin n_err++; $display("FAIL fa_head got %0d expected 30", commit_rob_idx); end
    tick();
    idle();
    n_vec++; if (dbg_state !== ROB_RUN || disp_ready !== 1'b1) begin n_err++; $display("FAIL fa_run got state=%0d ready=%0b expected 0 1", dbg_state, disp_ready); end
    tick();
  endtask

  task automatic test_dead_wb();
    pulse_reset();
    repeat (4) begin drive(1, 0, 0, 0, 0, 0, 0); tick(); end
    drive(0, 1, 10, 0, 0, 0, 0); tick();
    idle();
    n_vec++; if (rob_count !== 6'd4 || commit_valid !== 1'b0 || disp_rob_idx !== 5'd4) begin
      n_err++; $display("FAIL dead_wb got count=%0d cvalid=%0b tail=%0d expected 4 0 4", rob_count, commit_valid, disp_rob_idx);
    end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    idle();
    n_vec++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'd0) begin n_err++; $display("FAIL live_wb got v=%0b idx=%0d expected 1 0", commit_valid, commit_rob_idx); end
    tick();
  endtask

  task automatic test_random();
    int wi;
    pulse_reset();
    for (int c = 0; c < 500; c++) begin
      if (m_tail > m_head && $urandom_range(0, 3) != 0)
        wi = (m_head + $urandom_range(0, m_tail - m_head - 1)) % DEPTH;
      else
        wi = $urandom_range(0, DEPTH - 1);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), wi, $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1));
      n_vec++; if (disp_ready !== e_ready || int'(disp_rob_idx) != e_didx) begin
        n_err++; $display("FAIL rnd_disp cyc=%0d got ready=%0b idx=%0d expected ready=%0b idx=%0d", c, disp_ready, disp_rob_idx, e_ready, e_didx);
      end
      n_vec++; if (commit_valid !== e_cvalid || int'(commit_rob_idx) != e_cidx) begin
        n_err++; $display("FAIL rnd_commit cyc=%0d got v=%0b idx=%0d expected v=%0b idx=%0d", c, commit_valid, commit_rob_idx, e_cvalid, e_cidx);
      end
      n_vec++; if (int'(rob_count) != e_count || rob_empty !== e_empty || rob_full !== e_full) begin
        n_err++; $display("FAIL rnd_occ cyc=%0d got count=%0d e=%0b f=%0b expected count=%0d e=%0b f=%0b", c, rob_count, rob_empty, rob_full, e_count, e_empty, e_full);
      end
      n_vec++; if ((dbg_state == ROB_RECOVER) !== m_recover) begin
        n_err++; $display("FAIL rnd_state cyc=%0d got %0d expected recover=%0b", c, dbg_state, m_recover);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    repeat (5) begin drive(1, 0, 0, 0, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (rob_count !== 6'd0 || rob_empty !== 1'b1 || rob_full !== 1'b0) begin
      n_err++; $display("FAIL arst_occ got count=%0d empty=%0b full=%0b expected 0 1 0", rob_count, rob_empty, rob_full);
    end
    n_vec++; if (disp_ready !== 1'b1 || disp_rob_idx !== 5'd0 || commit_valid !== 1'b0 || commit_rob_idx !== 5'd0) begin
      n_err++; $display("FAIL arst_ports got ready=%0b didx=%0d cvalid=%0b cidx=%0d expected 1 0 0 0", disp_ready, disp_rob_idx, commit_valid, commit_rob_idx);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_wb_order();
    test_full_commit();
    test_partial_flush();
    test_flush_all();
    test_dead_wb();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
